// File: rtl/phtrk_sym_sched_if.sv
// ---------------------------------------------------------------------------
// phtrk_sym_sched_if
// Wishbone-style single-lane sample bus used on both sides of the PhaseTrack
// symbol scheduler.
//   dat  32  sample {Im[31:16], Re[15:0]}
//   cyc   1  bus cycle open
//   stb   1  sample valid
//   we    1  write qualifier
//   ack   1  accept from the slave
// master drives dat/cyc/stb/we and receives ack; slave is the mirror.
// ---------------------------------------------------------------------------
interface phtrk_sym_sched_if;
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    modport master (output dat, output cyc, output stb, output we, input ack);
    modport slave  (input dat, input cyc, input stb, input we, output ack);
endinterface

// File: rtl/phtrk_sym_sched.sv
// ---------------------------------------------------------------------------
// phtrk_sym_sched
// Symbol scheduler in front of PhaseTrack. Frames the upstream sample stream
// into n_sym symbols of NSC samples, pulses vec_ld_o with the latched
// allocation vector before each symbol, idles the downstream bus for GAP
// cycles between symbols and pulses frm_done_o at frame end.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   frm_start_i     one-cycle frame start request
//   n_sym_i         symbols in frame (sampled on accepted start)
//   alloc_in_i      allocation vector (sampled on accepted start)
//   up  (slave)     upstream sample bus, ack driven here
//   dn  (master)    downstream bus to PhaseTrack, we mirrors stb
//   alloc_vec_o     registered allocation vector
//   vec_ld_o        vector load strobe, one cycle per symbol
//   busy_o          high from accepted start until DONE exits
//   sym_idx_o       current symbol, 0-based
//   frm_done_o      one-cycle frame end pulse
//   err_ovr_o       sticky: start requested while not IDLE
//   err_tmo_o       sticky stall-watchdog error (PT_TIMEOUT_EN only)
//
// Build option: define PT_TIMEOUT_EN to add the stream stall watchdog
// (limit TMO cycles) and the err_tmo_o port.
//
// state    | meaning
// S_IDLE   | waiting for frm_start_i
// S_LOAD   | one cycle, vec_ld_o high, alloc_vec_o valid
// S_STREAM | forwarding NSC samples through the output register
// S_GAP    | downstream cycle closed for GAP cycles
// S_DONE   | one cycle, frm_done_o high
// ---------------------------------------------------------------------------
module phtrk_sym_sched #(
    parameter int NSC   = 200,
    parameter int VEC_W = 400,
    parameter int GAP   = 2,
    parameter int TMO   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frm_start_i,
    input  logic [7:0]           n_sym_i,
    input  logic [VEC_W-1:0]     alloc_in_i,
    phtrk_sym_sched_if.slave     up,
    phtrk_sym_sched_if.master    dn,
    output logic [VEC_W-1:0]     alloc_vec_o,
    output logic                 vec_ld_o,
    output logic                 busy_o,
    output logic [7:0]           sym_idx_o,
    output logic                 frm_done_o,
    output logic                 err_ovr_o
`ifdef PT_TIMEOUT_EN
    ,
    output logic                 err_tmo_o
`endif
);

    localparam int CNT_W = $clog2(NSC + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    if (GAP < 1 || TMO < 1 || NSC < 1) begin : g_bad_param
        $error("phtrk_sym_sched: NSC, GAP and TMO must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         n_sym_q, n_sym_d;
    logic [VEC_W-1:0]   alloc_q, alloc_d;
    logic [7:0]         sym_idx_q, sym_idx_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [31:0]        dat_q, dat_d;
    logic               stb_q, stb_d;
    logic               err_ovr_q, err_ovr_d;
    logic               ack_up;
    logic               up_xfer;
    logic               dn_xfer;

`ifdef PT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_tmo_q, err_tmo_d;
`endif

    // Single-entry output register: accept upstream whenever the register is
    // empty or draining this cycle, so full-rate flow has no bubble.
    assign ack_up  = (state_q == S_STREAM) && (in_cnt_q < CNT_W'(NSC)) && (!stb_q || dn.ack);
    assign up_xfer = up.cyc && up.stb && up.we && ack_up;
    assign dn_xfer = stb_q && dn.ack;

    always_comb begin
        state_d   = state_q;
        n_sym_d   = n_sym_q;
        alloc_d   = alloc_q;
        sym_idx_d = sym_idx_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        gap_d     = gap_q;
        dat_d     = dat_q;
        stb_d     = stb_q;
        err_ovr_d = err_ovr_q | (frm_start_i && (state_q != S_IDLE));
`ifdef PT_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_tmo_d = err_tmo_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (frm_start_i) begin
                    n_sym_d   = n_sym_i;
                    alloc_d   = alloc_in_i;
                    sym_idx_d = 8'd0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (n_sym_i == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef PT_TIMEOUT_EN
                tmo_d   = TMO_W'(TMO - 1);
`endif
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (up_xfer) begin
                    dat_d    = up.dat;
                    stb_d    = 1'b1;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                end else if (dn_xfer) begin
                    stb_d = 1'b0;
                end
                if (dn_xfer) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == CNT_W'(NSC - 1)) begin
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        gap_d     = GAP_W'(GAP - 1);
                        state_d   = (sym_idx_q == n_sym_q - 8'd1) ? S_DONE : S_GAP;
                    end
                end
`ifdef PT_TIMEOUT_EN
                // Down-counter reloads on any movement; terminal count after
                // TMO consecutive idle cycles aborts the frame.
                if (up_xfer || dn_xfer) begin
                    tmo_d = TMO_W'(TMO - 1);
                end else if (tmo_q == '0) begin
                    err_tmo_d = 1'b1;
                    stb_d     = 1'b0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
`endif
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    sym_idx_d = sym_idx_q + 8'd1;
                    state_d   = S_LOAD;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_sym_q   <= 8'd0;
            alloc_q   <= '0;
            sym_idx_q <= 8'd0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            gap_q     <= '0;
            dat_q     <= 32'd0;
            stb_q     <= 1'b0;
            err_ovr_q <= 1'b0;
`ifdef PT_TIMEOUT_EN
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            n_sym_q   <= n_sym_d;
            alloc_q   <= alloc_d;
            sym_idx_q <= sym_idx_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            gap_q     <= gap_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            err_ovr_q <= err_ovr_d;
`ifdef PT_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
`endif
        end
    end

    // The downstream cycle opens with the vector load so that the bus is
    // closed for exactly GAP cycles between consecutive symbols.
    assign dn.cyc      = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign dn.stb      = stb_q;
    assign dn.we       = stb_q;
    assign dn.dat      = dat_q;
    assign up.ack      = ack_up;
    assign alloc_vec_o = alloc_q;
    assign vec_ld_o    = (state_q == S_LOAD);
    assign busy_o      = (state_q != S_IDLE);
    assign sym_idx_o   = sym_idx_q;
    assign frm_done_o  = (state_q == S_DONE);
    assign err_ovr_o   = err_ovr_q;
`ifdef PT_TIMEOUT_EN
    assign err_tmo_o   = err_tmo_q;
`endif

endmodule
